input_conditioner: RTL and testbench



---
 rtl/input_pkg.sv | 18 +
 rtl/input_channel.sv | 147 ++++++++++++++
 rtl/input_conditioner.sv | 62 ++++++
 tb/tb_input_conditioner.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
// Shared types and helpers for the input conditioner: repeat-FSM state
// encoding, default tick constant and a counter-width helper.
package input_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  localparam int unsigned TICK_1MS_50MHZ = 50000;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_channel.sv
// One conditioner channel: 2-FF synchroniser, tick-based debounce, press/release
// pulses and, with INPUT_AUTOREPEAT_EN defined, a hold-to-repeat FSM.
//
// state      | meaning
// RPT_IDLE   | key up, no repeat activity
// RPT_DELAY  | key held, counting DAS_TICKS to the first repeat
// RPT_REPEAT | key held, one repeat every ARR_TICKS
module input_channel
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 5
`ifdef INPUT_AUTOREPEAT_EN
  ,
  parameter int unsigned DAS_TICKS      = 170,
  parameter int unsigned ARR_TICKS      = 50
`endif
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic tick,
  input  logic raw_in,
  output logic level,
  output logic press,
  output logic release_o,
  output logic fire
);

  localparam int unsigned DB_W = cnt_width(DEBOUNCE_TICKS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

  logic            sync0_q, sync1_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            fire_q, fire_d;

  always_comb begin
    level_d   = level_q;
    db_cnt_d  = db_cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync1_q == level_q) begin
      db_cnt_d = '0;
    end else if (tick) begin
      if (db_cnt_q == DB_LAST) begin
        level_d   = sync1_q;
        db_cnt_d  = '0;
        press_d   = sync1_q;
        release_d = ~sync1_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

`ifdef INPUT_AUTOREPEAT_EN
  localparam int unsigned RP_MAX = (DAS_TICKS > ARR_TICKS) ? DAS_TICKS : ARR_TICKS;
  localparam int unsigned RP_W   = cnt_width(RP_MAX);
  localparam logic [RP_W-1:0] DAS_LAST = RP_W'(DAS_TICKS - 1);
  localparam logic [RP_W-1:0] ARR_LAST = RP_W'(ARR_TICKS - 1);

  rpt_state_e      state_q, state_d;
  logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
  logic            rpt_fire;

  always_comb begin
    state_d  = state_q;
    rp_cnt_d = rp_cnt_q;
    rpt_fire = 1'b0;
    case (state_q)
      RPT_IDLE: ;
      RPT_DELAY: begin
        if (tick) begin
          if (rp_cnt_q == DAS_LAST) begin
            rpt_fire = 1'b1;
            state_d  = RPT_REPEAT;
            rp_cnt_d = '0;
          end else begin
            rp_cnt_d = rp_cnt_q + 1'b1;
          end
        end
      end
      RPT_REPEAT: begin
        if (tick) begin
          if (rp_cnt_q == ARR_LAST) begin
            rpt_fire = 1'b1;
            rp_cnt_d = '0;
          end else begin
            rp_cnt_d = rp_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = RPT_IDLE;
    endcase
    if (press_d) begin
      state_d  = RPT_DELAY;
      rp_cnt_d = '0;
    end
    // A release wins over a repeat tick landing in the same cycle.
    if (release_d) begin
      state_d  = RPT_IDLE;
      rp_cnt_d = '0;
      rpt_fire = 1'b0;
    end
    fire_d = press_d | rpt_fire;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= RPT_IDLE;
      rp_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rp_cnt_q <= rp_cnt_d;
    end
  end
`else
  always_comb fire_d = press_d;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync0_q   <= 1'b0;
      sync1_q   <= 1'b0;
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      fire_q    <= 1'b0;
    end else begin
      sync0_q   <= raw_in;
      sync1_q   <= sync0_q;
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      fire_q    <= fire_d;
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign release_o = release_q;
  assign fire      = fire_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input front end: shared tick prescaler plus one input_channel
// per raw input. Auto-repeat is built in when INPUT_AUTOREPEAT_EN is defined.
module input_conditioner
  import input_pkg::*;
#(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned TICK_DIV       = TICK_1MS_50MHZ,
  parameter int unsigned DEBOUNCE_TICKS = 5,
  parameter int unsigned DAS_TICKS      = 170,
  parameter int unsigned ARR_TICKS      = 50
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  // "release" is a reserved word, hence the _o suffix.
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] fire
);

  if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 || DAS_TICKS < 1 || ARR_TICKS < 1) begin : g_bad_params
    $error("input_conditioner: illegal parameter set");
  end

  localparam int unsigned PS_W = cnt_width(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
  logic            tick;

  always_comb begin
    tick     = (ps_cnt_q == PS_LAST);
    ps_cnt_d = tick ? '0 : ps_cnt_q + 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) ps_cnt_q <= '0;
    else       ps_cnt_q <= ps_cnt_d;
  end

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    input_channel #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
`ifdef INPUT_AUTOREPEAT_EN
      ,
      .DAS_TICKS     (DAS_TICKS),
      .ARR_TICKS     (ARR_TICKS)
`endif
    ) u_ch (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .tick     (tick),
      .raw_in   (raw_in[i]),
      .level    (level[i]),
      .press    (press[i]),
      .release_o(release_o[i]),
      .fire     (fire[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (small tick/debounce/repeat values).
module tb_input_conditioner;

  localparam int N_CH = 4;

  logic            CLOCK_50 = 1'b0;
  logic            reset;
  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] level, press, release_o, fire;

  always #5 CLOCK_50 = ~CLOCK_50;

  input_conditioner #(
    .N_CH(4), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .DAS_TICKS(5), .ARR_TICKS(2)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .raw_in   (raw_in),
    .level    (level),
    .press    (press),
    .release_o(release_o),
    .fire     (fire)
  );

  // kind: 0 press, 1 release, 2 fire
  typedef struct { int cyc; int ch; int kind; } ev_t;
  typedef struct { int ch; int kind; bit rel; int lo; int hi; } exp_t;
  typedef struct { logic [3:0] raw; int hold; logic [3:0] lvl; } vec_t;

  ev_t  obs_q[$];
  exp_t exp_q[$];
  vec_t tbl[6];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    for (int c = 0; c < N_CH; c++) begin
      if (press[c] === 1'b1)     obs_q.push_back('{cyc, c, 0});
      if (release_o[c] === 1'b1) obs_q.push_back('{cyc, c, 1});
      if (fire[c] === 1'b1)      obs_q.push_back('{cyc, c, 2});
    end
  end

  task automatic next_cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) next_cyc();
  endtask

  task automatic expect_ev(input int ch, input int kind, input bit rel, input int lo, input int hi);
    exp_q.push_back('{ch, kind, rel, lo, hi});
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic score(input string tag);
    ev_t  o;
    exp_t e;
    int   prev = 0;
    int   lo, hi;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no event seen, required ch%0d kind%0d", tag, e.ch, e.kind);
      end else begin
        o  = obs_q.pop_front();
        lo = e.rel ? prev + e.lo : e.lo;
        hi = e.rel ? prev + e.hi : e.hi;
        if (o.ch != e.ch || o.kind != e.kind || o.cyc < lo || o.cyc > hi) begin
          errors++;
          $display("FAIL %s: got ch%0d kind%0d at %0d, required ch%0d kind%0d in [%0d,%0d]",
                   tag, o.ch, o.kind, o.cyc, e.ch, e.kind, lo, hi);
        end
        prev = o.cyc;
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d unexpected events, first ch%0d kind%0d at %0d, required none",
               tag, obs_q.size(), obs_q[0].ch, obs_q[0].kind, obs_q[0].cyc);
    end
    obs_q.delete();
  endtask

  initial begin
    int  r_cyc, a_cyc, d_cyc, p_cyc;
    bit  found;

    tbl[0] = '{4'b0001, 20, 4'b0001};
    tbl[1] = '{4'b0011, 20, 4'b0011};
    tbl[2] = '{4'b1010, 20, 4'b1010};
    tbl[3] = '{4'b1011,  6, 4'b1010};
    tbl[4] = '{4'b1010, 20, 4'b1010};
    tbl[5] = '{4'b0000, 20, 4'b0000};

    // Reset with all keys held high
    reset  = 1'b1;
    raw_in = 4'b1111;
    repeat (10) begin
      @(negedge CLOCK_50);
      check("reset_quiet", {level, press, release_o, fire}, 32'h0);
    end
    @(posedge CLOCK_50);
    #1;
    r_cyc = cyc;
    reset = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (c == 0) expect_ev(c, 0, 1'b0, r_cyc + 11, r_cyc + 15);
      else        expect_ev(c, 0, 1'b1, 0, 0);
      expect_ev(c, 2, 1'b1, 0, 0);
    end
    next_cyc();
    @(negedge CLOCK_50);
    check("post_reset_quiet", {level, press, release_o, fire}, 32'h0);
    wait_until(r_cyc + 16);
    raw_in = 4'b0000;
    d_cyc  = cyc;
    for (int c = 0; c < N_CH; c++) begin
      if (c == 0) expect_ev(c, 1, 1'b0, d_cyc + 11, d_cyc + 15);
      else        expect_ev(c, 1, 1'b1, 0, 0);
    end
    wait_until(d_cyc + 30);
    score("reset_press");

    // Table of settled levels
    for (int i = 0; i < 6; i++) begin
      raw_in = tbl[i].raw;
      repeat (tbl[i].hold) next_cyc();
      @(negedge CLOCK_50);
      check($sformatf("level_vec%0d", i), {28'h0, level}, {28'h0, tbl[i].lvl});
    end
    next_cyc();
    obs_q.delete();

    // Bounce shorter than the debounce window
    raw_in[0] = 1'b1;
    repeat (6) next_cyc();
    raw_in[0] = 1'b0;
    repeat (30) next_cyc();
    check("bounce_level0", {31'h0, level[0]}, 32'h0);
    score("bounce");

    // Press and hold ch1, release lands on a repeat tick
    a_cyc = cyc;
    raw_in[1] = 1'b1;
    expect_ev(1, 0, 1'b0, a_cyc + 11, a_cyc + 15);
    expect_ev(1, 2, 1'b1, 0, 0);
`ifdef INPUT_AUTOREPEAT_EN
    expect_ev(1, 2, 1'b1, 20, 20);
    expect_ev(1, 2, 1'b1, 8, 8);
    expect_ev(1, 1, 1'b1, 8, 8);
`else
    expect_ev(1, 1, 1'b1, 36, 36);
`endif
    found = 1'b0;
    p_cyc = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge CLOCK_50);
      if (press[1] === 1'b1) begin
        found = 1'b1;
        p_cyc = cyc;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL hold_press_wait: got no press[1] in 20 cycles, required one");
      p_cyc = cyc;
    end
    wait_until(p_cyc + 23);
    raw_in[1] = 1'b0;
    wait_until(p_cyc + 60);
    score("hold_release");
    @(negedge CLOCK_50);
    check("hold_level1", {31'h0, level[1]}, 32'h0);

    // Independence: ch2 and ch3 together, ch3 dropped early
    while (((cyc + 3 - r_cyc) % 4) != 0) next_cyc();
    a_cyc = cyc;
    raw_in[3:2] = 2'b11;
    expect_ev(2, 0, 1'b0, a_cyc + 11, a_cyc + 11);
    expect_ev(2, 2, 1'b0, a_cyc + 11, a_cyc + 11);
    expect_ev(3, 0, 1'b0, a_cyc + 11, a_cyc + 11);
    expect_ev(3, 2, 1'b0, a_cyc + 11, a_cyc + 11);
    expect_ev(3, 1, 1'b0, a_cyc + 23, a_cyc + 23);
`ifdef INPUT_AUTOREPEAT_EN
    expect_ev(2, 2, 1'b0, a_cyc + 31, a_cyc + 31);
    expect_ev(2, 2, 1'b0, a_cyc + 39, a_cyc + 39);
    expect_ev(2, 2, 1'b0, a_cyc + 47, a_cyc + 47);
`endif
    expect_ev(2, 1, 1'b0, a_cyc + 51, a_cyc + 51);
    wait_until(a_cyc + 9);
    raw_in[3] = 1'b0;
    wait_until(a_cyc + 40);
    raw_in[2] = 1'b0;
    wait_until(a_cyc + 70);
    score("independence");
    @(negedge CLOCK_50);
    check("final_levels", {28'h0, level}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
